// File: rtl/button_debouncer.sv
// button_debouncer
//   Turns a raw, bouncing pushbutton pin into a clean pressed level and
//   single-cycle press / release / long-press strobes, all synchronous to
//   clock. The pin passes through a SYNC_STAGES-deep synchroniser before
//   any other logic sees it. A four-state FSM then accepts a change only
//   after DEBOUNCE_CYCLES consecutive cycles of the new value. A hold
//   counter raises btn_long once per press, after LONG_CYCLES cycles of
//   btn_level=1.
module button_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 120000,   // >= 2
   parameter int unsigned LONG_CYCLES     = 12000000, // >= 1
   parameter int unsigned SYNC_STAGES     = 2,        // >= 2
   parameter bit          ACTIVE_LOW      = 1'b1
) (
   input  logic clock,
   input  logic rst_btn,
   input  logic btn_in,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release,
   output logic btn_long
);

   // ------------------------------------------------------------------
   // Derived constants
   // ------------------------------------------------------------------
   localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES);
   localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

   localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);
   localparam logic [HOLD_W-1:0] HOLD_MAX    = HOLD_W'(LONG_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_BEFORE = HOLD_W'(LONG_CYCLES - 1);

   // Pin level while the button is not pressed; the synchroniser resets
   // to it so that reset deassertion never looks like a press edge.
   localparam logic IDLE_PIN = ACTIVE_LOW ? 1'b1 : 1'b0;

   // FSM encoding
   localparam logic [1:0] S_RELEASED     = 2'd0;
   localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
   localparam logic [1:0] S_PRESSED      = 2'd2;
   localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

   // ------------------------------------------------------------------
   // Signals
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   pressed;

   logic [1:0]             state_q;
   logic [1:0]             state_d;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_d;
   logic                   accept_press;
   logic                   accept_release;

   logic [HOLD_W-1:0]      hold_q;
   logic                   hold_active;

   // ------------------------------------------------------------------
   // Synchroniser: shift the raw pin through SYNC_STAGES flops
   // ------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // the values from before the edge, regardless of statement order.
   always_ff @(posedge clock or negedge rst_btn) begin
      if (!rst_btn) begin
         sync_q <= {SYNC_STAGES{IDLE_PIN}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
      end
   end

   // Normalise polarity: pressed = 1 means the button is held down.
   assign pressed = ACTIVE_LOW ? ~sync_q[SYNC_STAGES-1] : sync_q[SYNC_STAGES-1];

   // ------------------------------------------------------------------
   // Debounce FSM: next state, counter and acceptance pulses
   // ------------------------------------------------------------------
   // NOTE: every output of this block gets a default first, so no path
   // leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      accept_press   = 1'b0;
      accept_release = 1'b0;

      case (state_q)
         S_RELEASED: begin
            if (pressed) begin
               state_d = S_PRESS_WAIT;
               cnt_d   = CNT_ONE;
            end
         end

         S_PRESS_WAIT: begin
            if (!pressed) begin
               // Bounce: fall back silently.
               state_d = S_RELEASED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d      = S_PRESSED;
               cnt_d        = '0;
               accept_press = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         S_PRESSED: begin
            if (!pressed) begin
               state_d = S_RELEASE_WAIT;
               cnt_d   = CNT_ONE;
            end
         end

         S_RELEASE_WAIT: begin
            if (pressed) begin
               // Glitch while held: stay pressed, level never dropped.
               state_d = S_PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d        = S_RELEASED;
               cnt_d          = '0;
               accept_release = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         default: begin
            state_d = S_RELEASED;
            cnt_d   = '0;
         end
      endcase
   end

   // Debounce FSM state and counter registers
   always_ff @(posedge clock or negedge rst_btn) begin
      if (!rst_btn) begin
         state_q <= S_RELEASED;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Debounced level plus registered press / release strobes
   always_ff @(posedge clock or negedge rst_btn) begin
      if (!rst_btn) begin
         btn_level   <= 1'b0;
         btn_press   <= 1'b0;
         btn_release <= 1'b0;
      end else begin
         btn_press   <= accept_press;
         btn_release <= accept_release;
         if (accept_press) begin
            btn_level <= 1'b1;
         end else if (accept_release) begin
            btn_level <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Long-press detection
   // ------------------------------------------------------------------
   // The hold counter runs only while the level is high and the release
   // is not being accepted on this edge, so btn_long can never share a
   // cycle with btn_release. It idles at zero while released, which also
   // gives the clear-on-rise behaviour.
   assign hold_active = btn_level & ~accept_release;

   // Hold counter: count cycles of btn_level=1, saturate at LONG_CYCLES
   always_ff @(posedge clock or negedge rst_btn) begin
      if (!rst_btn) begin
         hold_q <= '0;
      end else if (!btn_level) begin
         hold_q <= '0;
      end else if (hold_active && (hold_q != HOLD_MAX)) begin
         hold_q <= hold_q + HOLD_ONE;
      end
   end

   // Long-press strobe: fires on the edge the hold count reaches LONG_CYCLES
   always_ff @(posedge clock or negedge rst_btn) begin
      if (!rst_btn) begin
         btn_long <= 1'b0;
      end else begin
         btn_long <= hold_active && (hold_q == HOLD_BEFORE);
      end
   end

   // ------------------------------------------------------------------
   // Structural properties of the outputs
   // ------------------------------------------------------------------
   a_press_release_exclusive : assert property (
      @(posedge clock) disable iff (!rst_btn) !(btn_press && btn_release));

   a_press_one_cycle : assert property (
      @(posedge clock) disable iff (!rst_btn) btn_press |=> !btn_press);

   a_release_one_cycle : assert property (
      @(posedge clock) disable iff (!rst_btn) btn_release |=> !btn_release);

   a_long_one_cycle : assert property (
      @(posedge clock) disable iff (!rst_btn) btn_long |=> !btn_long);

   a_long_needs_level : assert property (
      @(posedge clock) disable iff (!rst_btn) btn_long |-> btn_level);

endmodule
